// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer in front of the shared 32-bit
// combinational ALU (alu_32bits). Two requesters, one registered response.
// Optional feature macro: ALU_SHARE_ERR_EN adds the rsp_err output
// (divide-by-zero flag registered alongside rsp_data).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. reqN_valid and its payload are held by the requester until
// reqN_ready; rsp_valid, rsp_data and rsp_id are held by this block until
// rsp_ready. reqN_ready is a combinational function of reqN_valid in IDLE.

module alu_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  output logic [31:0] y
);

  // Pure combinational operation decode; all results wrap modulo 2^32.
  always_comb begin
    y = '0;
    case (sel)
      3'b000: y = ~a;
      3'b001: y = a | b;
      3'b010: y = a & b;
      3'b011: y = 32'd0 - a;
      3'b100: y = a + b;
      3'b101: y = a - b;
      3'b110: y = a * b;
      3'b111: y = (b == 32'd0) ? 32'd0 : (a / b);
      default: y = '0;
    endcase
  end

endmodule

module alu_share_ctrl #(
  parameter int MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_id,
  output logic        busy
`ifdef ALU_SHARE_ERR_EN
  ,
  output logic        rsp_err
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Mul/div hold count minus one; the EXEC cycle with counter 0 is the last.
  localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

  state_t      state, state_next;
  logic [31:0] op_a, op_b;
  logic [2:0]  op_sel;
  logic        op_id;
  logic [3:0]  cnt;
  logic        last_grant;

  logic        grant;
  logic        grant_id;
  logic [31:0] in_a, in_b;
  logic [2:0]  in_sel;
  logic        exec_done;
  logic        rsp_fire;
  logic [31:0] alu_y;

  alu_32bits u_alu (
    .a   (op_a),
    .b   (op_b),
    .sel (op_sel),
    .y   (alu_y)
  );

  // Round-robin grant and payload select; ready only in IDLE for the winner.
  always_comb begin
    grant    = (state == IDLE) && (req0_valid || req1_valid);
    grant_id = (req0_valid && req1_valid) ? ~last_grant : ~req0_valid;
    in_a     = grant_id ? req1_a   : req0_a;
    in_b     = grant_id ? req1_b   : req0_b;
    in_sel   = grant_id ? req1_sel : req0_sel;
    req0_ready = grant && !grant_id;
    req1_ready = grant &&  grant_id;
    exec_done  = (state == EXEC) && (cnt == 4'd0);
    rsp_fire   = (state == RESP) && rsp_valid && rsp_ready;
    busy       = (state != IDLE);
  end

  // Next-state decode for the IDLE -> EXEC -> RESP loop.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (grant)     state_next = EXEC;
      EXEC: if (exec_done) state_next = RESP;
      RESP: if (rsp_fire)  state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Operand capture at grant, EXEC hold counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      op_id      <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
    end else if (grant) begin
      op_a       <= in_a;
      op_b       <= in_b;
      op_sel     <= in_sel;
      op_id      <= grant_id;
      cnt        <= (in_sel[2:1] == 2'b11) ? LAT_M1 : 4'd0;
      last_grant <= grant_id;
    end else if ((state == EXEC) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response register: loaded on the last EXEC cycle, held until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
`ifdef ALU_SHARE_ERR_EN
      rsp_err   <= 1'b0;
`endif
    end else if (exec_done) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_y;
      rsp_id    <= op_id;
`ifdef ALU_SHARE_ERR_EN
      rsp_err   <= (op_sel == 3'b111) && (op_b == 32'd0);
`endif
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: reset checks, directed corner sequences, a
// vector table over every opcode, then randomized traffic against a
// transaction-level reference model with an expected-result queue.
`timescale 1ns/1ps

module tb_alu_share_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_sel;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_sel;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        busy;
`ifdef ALU_SHARE_ERR_EN
  logic        rsp_err;
`endif

  alu_share_ctrl #(.MULDIV_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_sel   (req0_sel),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_sel   (req1_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
`ifdef ALU_SHARE_ERR_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard state
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic [33:0] exp_q[$];   // {err, id, data}
  int          due_q[$];   // cycle in which rsp_valid must first appear
  bit   model_last;
  bit   model_free;
  bit   hs0, hs1;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sel;
    logic [31:0] y;
  } vec_t;
  vec_t vecs[15];

  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [2:0] sel);
    longint unsigned ua, ub;
    ua = a;
    ub = b;
    case (sel)
      3'd0: return ~a;
      3'd1: return a | b;
      3'd2: return a & b;
      3'd3: return 32'((64'h1_0000_0000 - ua) % 64'h1_0000_0000);
      3'd4: return 32'((ua + ub) % 64'h1_0000_0000);
      3'd5: return 32'((ua + 64'h1_0000_0000 - ub) % 64'h1_0000_0000);
      3'd6: return 32'((ua * ub) % 64'h1_0000_0000);
      default: return (b == 0) ? 32'd0 : 32'(ua / ub);
    endcase
  endfunction

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sel = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sel = 0;
    rsp_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_op(vec_t v);
    int k;
    int lat;
    bit seen;
    @(posedge clk); #1;
    if (!v.id) begin req0_valid = 1; req0_a = v.a; req0_b = v.b; req0_sel = v.sel; end
    else       begin req1_valid = 1; req1_a = v.a; req1_b = v.b; req1_sel = v.sel; end
    rsp_ready = 1;
    @(negedge clk);
    check("vec_ready0", req0_ready, !v.id);
    check("vec_ready1", req1_ready, v.id);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
    lat  = (v.sel[2:1] == 2'b11) ? LAT : 1;
    k    = 0;
    seen = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin seen = 1; k = i; end
    end
    check("vec_latency", k, lat + 1);
    check("vec_data", rsp_data, v.y);
    check("vec_id", rsp_id, v.id);
`ifdef ALU_SHARE_ERR_EN
    check("vec_err", rsp_err, (v.sel == 3'b111) && (v.b == 0));
`endif
    @(negedge clk);
    check("vec_after_valid", rsp_valid, 0);
    check("vec_after_busy", busy, 0);
  endtask

  // One cycle of random traffic with the reference model checking it.
  task automatic rand_cycle(bit allow_new);
    bit exp_grant, win, exp_v;
    logic [31:0] a, b, y;
    logic [2:0]  s;
    int lat;
    @(posedge clk); #1;
    if (hs0) req0_valid = 0;
    if (hs1) req1_valid = 0;
    hs0 = 0;
    hs1 = 0;
    if (allow_new) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_valid = 1; req0_a = rand_word(); req0_b = rand_word(); req0_sel = 3'($urandom_range(0, 7));
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_valid = 1; req1_a = rand_word(); req1_b = rand_word(); req1_sel = 3'($urandom_range(0, 7));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end else begin
      rsp_ready = 1;
    end
    @(negedge clk);
    cyc++;
    exp_grant = model_free && (req0_valid || req1_valid);
    check("rnd_busy", busy, !model_free);
    check("rnd_grant", req0_ready | req1_ready, exp_grant);
    if (exp_grant) begin
      win = (req0_valid && req1_valid) ? !model_last : !req0_valid;
      check("rnd_win0", req0_ready, !win);
      check("rnd_win1", req1_ready, win);
      a = win ? req1_a : req0_a;
      b = win ? req1_b : req0_b;
      s = win ? req1_sel : req0_sel;
      y = ref_alu(a, b, s);
      lat = (s >= 3'd6) ? LAT : 1;
      exp_q.push_back({(s == 3'd7) && (b == 0), win, y});
      due_q.push_back(cyc + lat + 1);
      model_last = win;
      model_free = 0;
      if (win) hs1 = 1; else hs0 = 1;
    end
    exp_v = 0;
    if (exp_q.size() > 0) exp_v = (cyc >= due_q[0]);
    check("rnd_rsp_valid", rsp_valid, exp_v);
    if (rsp_valid && exp_q.size() > 0) begin
      check("rnd_data", rsp_data, exp_q[0][31:0]);
      check("rnd_id", rsp_id, exp_q[0][32]);
`ifdef ALU_SHARE_ERR_EN
      check("rnd_err", rsp_err, exp_q[0][33]);
`endif
      if (rsp_ready) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        model_free = 1;
      end
    end
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd5,          32'd3,          3'b100, 32'd8};
    vecs[1]  = '{1'b0, 32'h0000_00F0,  32'h0000_000F,  3'b001, 32'h0000_00FF};
    vecs[2]  = '{1'b1, 32'd7,          32'd2,          3'b101, 32'd5};
    vecs[3]  = '{1'b1, 32'h0001_0000,  32'h0001_0000,  3'b110, 32'd0};
    vecs[4]  = '{1'b0, 32'd100,        32'd7,          3'b111, 32'd14};
    vecs[5]  = '{1'b1, 32'd9,          32'd0,          3'b111, 32'd0};
    vecs[6]  = '{1'b0, 32'h1234_5678,  32'hDEAD_BEEF,  3'b000, 32'hEDCB_A987};
    vecs[7]  = '{1'b1, 32'hFF00_FF00,  32'h0FF0_0FF0,  3'b010, 32'h0F00_0F00};
    vecs[8]  = '{1'b0, 32'd1,          32'd0,          3'b011, 32'hFFFF_FFFF};
    vecs[9]  = '{1'b1, 32'd0,          32'd5,          3'b011, 32'd0};
    vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          3'b100, 32'd0};
    vecs[11] = '{1'b1, 32'd0,          32'd1,          3'b101, 32'hFFFF_FFFF};
    vecs[12] = '{1'b0, 32'h0000_FFFF,  32'h0001_0001,  3'b110, 32'hFFFF_FFFF};
    vecs[13] = '{1'b1, 32'hFFFF_FFFF,  32'd1,          3'b111, 32'hFFFF_FFFF};
    vecs[14] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  3'b111, 32'd0};

    do_reset();
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
`ifdef ALU_SHARE_ERR_EN
    check("rst_err", rsp_err, 0);
`endif

    // Tie straight out of reset: requester 0 first, requester 1 three cycles later.
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'hF0; req0_b = 32'h0F; req0_sel = 3'b001;
    req1_valid = 1; req1_a = 32'd7;  req1_b = 32'd2;  req1_sel = 3'b101;
    rsp_ready = 1;
    @(negedge clk);
    check("tie_ready0", req0_ready, 1);
    check("tie_ready1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    check("tie_exec_ready1", req1_ready, 0);
    check("tie_exec_busy", busy, 1);
    @(negedge clk);
    check("tie_rsp0_valid", rsp_valid, 1);
    check("tie_rsp0_data", rsp_data, 32'hFF);
    check("tie_rsp0_id", rsp_id, 0);
    check("tie_resp_ready1", req1_ready, 0);
    @(negedge clk);
    check("tie_grant1", req1_ready, 1);
    check("tie_idle_valid", rsp_valid, 0);
    @(posedge clk); #1;
    req1_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("tie_rsp1_valid", rsp_valid, 1);
    check("tie_rsp1_data", rsp_data, 32'd5);
    check("tie_rsp1_id", rsp_id, 1);
    @(negedge clk);
    check("tie_done_busy", busy, 0);

    // Opcode table
    foreach (vecs[i]) do_op(vecs[i]);

    // Backpressure: response held for 10 cycles while requester 0 waits.
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd3; req0_sel = 3'b100;
    rsp_ready = 0;
    @(negedge clk);
    check("bp_grant", req0_ready, 1);
    @(posedge clk); #1;
    req0_a = 32'd1; req0_b = 32'd2; req0_sel = 3'b100;
    @(negedge clk);
    check("bp_exec_ready0", req0_ready, 0);
    @(negedge clk);
    check("bp_rsp_valid", rsp_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", rsp_valid, 1);
      check("bp_hold_data", rsp_data, 32'd8);
      check("bp_hold_id", rsp_id, 0);
      check("bp_hold_ready0", req0_ready, 0);
      check("bp_hold_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1;
    @(negedge clk);
    check("bp_hs_ready0", req0_ready, 0);
    check("bp_hs_valid", rsp_valid, 1);
    @(negedge clk);
    check("bp_regrant", req0_ready, 1);
    check("bp_regrant_valid", rsp_valid, 0);
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    @(negedge clk);
    check("bp_second_data", rsp_data, 32'd3);
    check("bp_second_valid", rsp_valid, 1);
    @(negedge clk);

    // Reset during the EXEC phase of a divide.
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'd100; req0_b = 32'd7; req0_sel = 3'b111;
    rsp_ready = 1;
    @(negedge clk);
    check("mrst_grant", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    #2;
    rst_n = 0;
    #1;
    check("mrst_valid", rsp_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_data", rsp_data, 0);
    check("mrst_ready0", req0_ready, 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mrst_no_rsp", rsp_valid, 0);
      check("mrst_idle", busy, 0);
    end

    // Randomized traffic; reset left the round-robin pointer at requester 1.
    model_last = 1;
    model_free = 1;
    hs0 = 0;
    hs1 = 0;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
    for (int i = 0; i < 200 && (exp_q.size() > 0 || req0_valid || req1_valid); i++) rand_cycle(1'b0);
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
